// File: rtl/galois_lfsr_checker.sv
// Receive-side hunt/check/lock checker for the 3-bit muxed Galois LFSR sequence (period 7).
// Optional zero-sample detection is compiled in with `define LFSR_CHK_ZERO_DET_EN.
module galois_lfsr_checker #(
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned LOSS_CNT = 4,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [2:0]       in_data_i,
  input  logic             clr_err_i,
  output logic             locked_o,
  output logic             err_pulse_o,
  output logic [ERR_W-1:0] err_count_o,
  output logic [2:0]       expect_o,
  output logic             zero_flag_o
);

  if (LOCK_CNT < 2 || LOCK_CNT > 7) begin : g_bad_lock_cnt
    $error("LOCK_CNT must be in 2..7");
  end
  if (LOSS_CNT < 1 || LOSS_CNT > 7) begin : g_bad_loss_cnt
    $error("LOSS_CNT must be in 1..7");
  end
  if (ERR_W < 2) begin : g_bad_err_w
    $error("ERR_W must be at least 2");
  end

  typedef enum logic [1:0] {
    StHunt,
    StCheck,
    StLocked
  } state_e;

  localparam logic [2:0] LockCnt = 3'(LOCK_CNT);
  localparam logic [2:0] LossCnt = 3'(LOSS_CNT);
  localparam logic [2:0] Seed    = 3'b001;

  function automatic logic [2:0] nxt(input logic [2:0] x);
    return {x[2] ^ x[1], x[0], x[2]};
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       expect_q, expect_d;
  logic [2:0]       match_cnt_q, match_cnt_d;
  logic [2:0]       miss_cnt_q, miss_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic             locked_q, locked_d;
  logic             zero_q, zero_d;

  logic             sample_zero;
  logic             sample_hit;
  logic             err_inc;
  logic [2:0]       match_cnt_inc;
  logic [2:0]       miss_cnt_inc;

  assign sample_zero   = (in_data_i == 3'b000);
  assign sample_hit    = (in_data_i == expect_q);
  assign match_cnt_inc = match_cnt_q + 3'd1;
  assign miss_cnt_inc  = miss_cnt_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    expect_d    = expect_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_inc     = 1'b0;

    if (in_valid_i) begin
      case (state_q)
        StHunt: begin
          if (!sample_zero) begin
            expect_d    = nxt(in_data_i);
            match_cnt_d = 3'd1;
            state_d     = StCheck;
          end
        end

        StCheck: begin
          if (sample_hit) begin
            expect_d    = nxt(expect_q);
            match_cnt_d = match_cnt_inc;
            if (match_cnt_inc == LockCnt) begin
              state_d    = StLocked;
              miss_cnt_d = 3'd0;
            end
          end else if (!sample_zero) begin
            // Reseed from the offending sample rather than dropping back to hunt.
            expect_d    = nxt(in_data_i);
            match_cnt_d = 3'd1;
          end else begin
            state_d     = StHunt;
            match_cnt_d = 3'd0;
          end
        end

        StLocked: begin
          // Flywheel: prediction advances on every valid sample, hit or miss.
          expect_d = nxt(expect_q);
`ifdef LFSR_CHK_ZERO_DET_EN
          if (sample_zero) begin
            err_inc    = 1'b1;
            state_d    = StHunt;
            miss_cnt_d = 3'd0;
          end else
`endif
          if (sample_hit) begin
            miss_cnt_d = 3'd0;
          end else begin
            err_inc    = 1'b1;
            miss_cnt_d = miss_cnt_inc;
            if (miss_cnt_inc == LossCnt) begin
              state_d    = StHunt;
              miss_cnt_d = 3'd0;
            end
          end
        end

        default: begin
          state_d = StHunt;
        end
      endcase
    end

    locked_d    = (state_d == StLocked);
    err_pulse_d = err_inc;

`ifdef LFSR_CHK_ZERO_DET_EN
    zero_d = zero_q | (in_valid_i & sample_zero);
`else
    zero_d = 1'b0;
`endif

    // Clear wins over a same-cycle increment; the pulse still reports the error.
    err_cnt_d = err_cnt_q;
    if (clr_err_i) begin
      err_cnt_d = '0;
      zero_d    = 1'b0;
    end else if (err_inc && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StHunt;
      expect_q    <= Seed;
      match_cnt_q <= 3'd0;
      miss_cnt_q  <= 3'd0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      expect_q    <= expect_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
      zero_q      <= zero_d;
    end
  end

  assign locked_o    = locked_q;
  assign err_pulse_o = err_pulse_q;
  assign err_count_o = err_cnt_q;
  assign expect_o    = expect_q;
  assign zero_flag_o = zero_q;

endmodule

// File: tb/tb_galois_lfsr_checker.sv
// Bench for galois_lfsr_checker: directed scenarios plus random stimulus against a phase-index
// model of the 7-state sequence; a second instance with ERR_W=2 shares the inputs.
module tb_galois_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  in_data;
  logic        clr_err;

  logic        locked, err_pulse, zero_flag;
  logic [15:0] err_count;
  logic [2:0]  expect_v;
  logic        locked2, err_pulse2, zero_flag2;
  logic [1:0]  err_count2;
  logic [2:0]  expect_v2;

  always #5 clk = ~clk;

  galois_lfsr_checker dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .clr_err_i   (clr_err),
    .locked_o    (locked),
    .err_pulse_o (err_pulse),
    .err_count_o (err_count),
    .expect_o    (expect_v),
    .zero_flag_o (zero_flag)
  );

  galois_lfsr_checker #(
    .ERR_W (2)
  ) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .clr_err_i   (clr_err),
    .locked_o    (locked2),
    .err_pulse_o (err_pulse2),
    .err_count_o (err_count2),
    .expect_o    (expect_v2),
    .zero_flag_o (zero_flag2)
  );

  // Sequence order of the generator; the model tracks a position in this list.
  int seq [7] = '{1, 2, 4, 5, 7, 3, 6};

  int n_cmp = 0;
  int n_err = 0;

  // 0 = hunt, 1 = check, 2 = locked
  int m_st, m_ph, m_mcnt, m_miss, m_cnt, m_cnt2, m_pulse, m_zf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pos_of(input int v);
    for (int i = 0; i < 7; i++) if (seq[i] == v) return i;
    return 0;
  endfunction

  task automatic model(input logic v, input logic [2:0] d, input logic c, input logic r);
    int dv;
    int err;
    dv  = int'(d);
    err = 0;
    if (r) begin
      m_st = 0; m_ph = 0; m_mcnt = 0; m_miss = 0;
      m_cnt = 0; m_cnt2 = 0; m_pulse = 0; m_zf = 0;
      return;
    end
    if (v) begin
`ifdef LFSR_CHK_ZERO_DET_EN
      if (dv == 0) m_zf = 1;
`endif
      if (m_st == 0) begin
        if (dv != 0) begin
          m_ph = (pos_of(dv) + 1) % 7; m_mcnt = 1; m_st = 1;
        end
      end else if (m_st == 1) begin
        if (dv == seq[m_ph]) begin
          m_ph = (m_ph + 1) % 7; m_mcnt++;
          if (m_mcnt == 3) begin m_st = 2; m_miss = 0; end
        end else if (dv != 0) begin
          m_ph = (pos_of(dv) + 1) % 7; m_mcnt = 1;
        end else begin
          m_st = 0;
        end
      end else begin
        int hit;
        hit  = (dv == seq[m_ph]);
        m_ph = (m_ph + 1) % 7;
`ifdef LFSR_CHK_ZERO_DET_EN
        if (dv == 0) begin
          err = 1; m_st = 0; m_miss = 0;
        end else
`endif
        if (hit != 0) m_miss = 0;
        else begin
          err = 1; m_miss++;
          if (m_miss == 4) begin m_st = 0; m_miss = 0; end
        end
      end
    end
    m_pulse = err;
    if (c) begin
      m_cnt = 0; m_cnt2 = 0; m_zf = 0;
    end else if (err != 0) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  task automatic compare_all();
    check("locked", 32'(locked), 32'(m_st == 2));
    check("err_pulse", 32'(err_pulse), 32'(m_pulse));
    check("err_count", 32'(err_count), 32'(m_cnt));
    check("expect", 32'(expect_v), 32'(seq[m_ph]));
    check("zero_flag", 32'(zero_flag), 32'(m_zf));
    check("sat_count", 32'(err_count2), 32'(m_cnt2));
    check("sat_locked", 32'(locked2), 32'(m_st == 2));
  endtask

  task automatic step(input logic v, input logic [2:0] d, input logic c, input logic r);
    in_valid = v; in_data = d; clr_err = c; rst = r;
    @(posedge clk);
    model(v, d, c, r);
    #1;
    compare_all();
  endtask

  function automatic logic [2:0] wrong();
    return 3'(seq[(m_ph + 3) % 7]);
  endfunction

  function automatic logic [2:0] right();
    return 3'(seq[m_ph]);
  endfunction

  task automatic do_reset();
    step(1'b0, 3'd0, 1'b0, 1'b1);
  endtask

  task automatic do_lock();
    step(1'b1, 3'b001, 1'b0, 1'b0);
    step(1'b1, 3'b010, 1'b0, 1'b0);
    step(1'b1, 3'b100, 1'b0, 1'b0);
  endtask

  initial begin
    logic       v, c, r;
    logic [2:0] d;
    int         k;
    in_valid = 1'b0; in_data = 3'd0; clr_err = 1'b0; rst = 1'b1;
    m_st = 0; m_ph = 0; m_mcnt = 0; m_miss = 0;
    m_cnt = 0; m_cnt2 = 0; m_pulse = 0; m_zf = 0;

    // Reset values
    do_reset();
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_expect", 32'(expect_v), 32'd1);
    check("rst_count", 32'(err_count), 32'd0);
    check("rst_zero", 32'(zero_flag), 32'd0);

    // Lock on the third consistent sample
    step(1'b1, 3'b001, 1'b0, 1'b0);
    step(1'b1, 3'b010, 1'b0, 1'b0);
    check("lock_early", 32'(locked), 32'd0);
    step(1'b1, 3'b100, 1'b0, 1'b0);
    check("lock_rise", 32'(locked), 32'd1);
    check("lock_expect", 32'(expect_v), 32'h5);
    check("lock_count", 32'(err_count), 32'd0);

    // Single error followed by a two-cycle gap
    step(1'b1, 3'b111, 1'b0, 1'b0);
    check("err1_pulse", 32'(err_pulse), 32'd1);
    check("err1_count", 32'(err_count), 32'd1);
    step(1'b0, 3'b000, 1'b0, 1'b0);
    check("gap_pulse", 32'(err_pulse), 32'd0);
    step(1'b0, 3'b101, 1'b0, 1'b0);
    step(1'b1, 3'b111, 1'b0, 1'b0);
    check("gap_locked", 32'(locked), 32'd1);
    check("gap_expect", 32'(expect_v), 32'h3);
    check("gap_count", 32'(err_count), 32'd1);

    // Loss of lock after four consecutive misses
    do_reset();
    do_lock();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, wrong(), 1'b0, 1'b0);
      check("loss_pulse", 32'(err_pulse), 32'd1);
    end
    check("loss_count", 32'(err_count), 32'd4);
    check("loss_locked", 32'(locked), 32'd0);

    // Saturation of the narrow counter, then clear against a same-cycle error
    do_reset();
    do_lock();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, wrong(), 1'b0, 1'b0);
      step(1'b1, right(), 1'b0, 1'b0);
    end
    check("sat_hold", 32'(err_count2), 32'd3);
    check("sat_wide", 32'(err_count), 32'd5);
    step(1'b1, wrong(), 1'b1, 1'b0);
    check("clr_count", 32'(err_count2), 32'd0);
    check("clr_wide", 32'(err_count), 32'd0);
    check("clr_pulse", 32'(err_pulse2), 32'd1);

    // Zero sample while locked
    do_reset();
    do_lock();
    step(1'b1, 3'b000, 1'b0, 1'b0);
    check("zero_count", 32'(err_count), 32'd1);
`ifdef LFSR_CHK_ZERO_DET_EN
    check("zero_flag_set", 32'(zero_flag), 32'd1);
    check("zero_unlock", 32'(locked), 32'd0);
    step(1'b1, 3'b110, 1'b0, 1'b0);
    step(1'b1, 3'b001, 1'b0, 1'b0);
    step(1'b1, 3'b010, 1'b0, 1'b0);
    check("zero_relock", 32'(locked), 32'd1);
    check("zero_sticky", 32'(zero_flag), 32'd1);
`else
    check("zero_flag_off", 32'(zero_flag), 32'd0);
    check("zero_stay", 32'(locked), 32'd1);
`endif

    // Reset during check and during lock, with a valid sample present
    do_reset();
    step(1'b1, 3'b001, 1'b0, 1'b0);
    step(1'b1, 3'b010, 1'b0, 1'b0);
    step(1'b1, 3'b100, 1'b0, 1'b1);
    check("rstchk_expect", 32'(expect_v), 32'd1);
    check("rstchk_locked", 32'(locked), 32'd0);
    do_lock();
    step(1'b1, wrong(), 1'b0, 1'b0);
    step(1'b1, right(), 1'b0, 1'b1);
    check("rstlck_locked", 32'(locked), 32'd0);
    check("rstlck_count", 32'(err_count), 32'd0);
    check("rstlck_expect", 32'(expect_v), 32'd1);
    check("rstlck_pulse", 32'(err_pulse), 32'd0);

    // Random stimulus biased toward the predicted sample
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 29) == 0);
      k = int'($urandom_range(0, 9));
      if (k < 7) d = right();
      else if (k == 7) d = 3'b000;
      else d = 3'($urandom);
      step(v, d, c, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
